// File: rtl/abr_keccak_squeeze.sv
// ---------------------------------------------------------------------------
// abr_keccak_squeeze
//
// Squeeze stage behind the Keccak round engine. It snapshots the rate words of
// the Keccak state and streams them out as OutW-bit words over valid/ready.
// When more words are requested than one rate block holds, it requests another
// squeeze permutation (keccak_run_o + keccak_squeezing_o). It then captures the
// new state on keccak_complete_i and keeps streaming until len_words_i words
// have been delivered. Masked shares are carried side by side and never
// combined.
//
// Ports
//   clk_i, rst_n          clock, asynchronous active-low reset
//   zeroize_i             synchronous wipe of buffer, counters and FSM
//   start_i               request pulse; keccak_state_i holds first digest state
//   rate_words_i          rate in OutW words (1..MaxWords-1), sampled at start_i
//   len_words_i           total words requested (non-zero), sampled at start_i
//   keccak_state_i        Share x Width state shares
//   keccak_ready_i        engine idle
//   keccak_complete_i     permutation done; state valid in the same cycle
//   keccak_run_o          one-cycle permutation request
//   keccak_squeezing_o    high with keccak_run_o (no message XOR)
//   dout_valid_o/ready_i  output handshake
//   dout_data_o           output word, one OutW slice per share
//   dout_last_o           marks the final word
//   busy_o                FSM not idle
//   done_o                one-cycle pulse after the last handshake
//   err_o                 one-cycle pulse on an illegal or busy start
//
// Build option
//   ABR_SQUEEZE_BUF_WIPE_EN : zero each buffer word the cycle after it is sent,
//   and the whole buffer on entry to DONE. Protocol timing is unchanged.
// ---------------------------------------------------------------------------
module abr_keccak_squeeze #(
    parameter int Width     = 1600,
    parameter int EnMasking = 0,
    parameter int OutW      = 64,
    parameter int MaxWords  = Width / OutW,
    localparam int Share    = (EnMasking != 0) ? 2 : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_n,
    input  logic                            zeroize_i,
    input  logic                            start_i,
    input  logic [4:0]                      rate_words_i,
    input  logic [15:0]                     len_words_i,
    input  logic [Share-1:0][Width-1:0]     keccak_state_i,
    input  logic                            keccak_ready_i,
    input  logic                            keccak_complete_i,
    output logic                            keccak_run_o,
    output logic                            keccak_squeezing_o,
    output logic                            dout_valid_o,
    input  logic                            dout_ready_i,
    output logic [Share-1:0][OutW-1:0]      dout_data_o,
    output logic                            dout_last_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
);

    localparam int         BufWords = MaxWords - 1;
    localparam logic [4:0] MaxRate  = 5'(BufWords);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_RUN,
        ST_WAIT_PERM,
        ST_DONE
    } state_e;

    state_e          state_q;
    logic [4:0]      idx_q;
    logic [4:0]      rate_q;
    logic [15:0]     rem_q;
    logic            run_q;
    logic            err_q;
    logic [OutW-1:0] word_buf [Share][BufWords];

    logic            start_legal;
    logic            hs;
    logic            cap_en;
    logic [4:0]      cap_rate;

    assign start_legal = (rate_words_i != 5'd0) && (rate_words_i <= MaxRate) &&
                         (len_words_i != 16'd0);
    assign hs          = dout_valid_o && dout_ready_i;

    // The first block is captured straight from the start request; later
    // blocks use the rate latched at start, since rate_words_i may change.
    assign cap_en   = ((state_q == ST_IDLE) && start_i && start_legal) ||
                      ((state_q == ST_WAIT_PERM) && keccak_complete_i);
    assign cap_rate = (state_q == ST_IDLE) ? rate_words_i : rate_q;

    assign dout_valid_o       = (state_q == ST_STREAM);
    assign dout_last_o        = dout_valid_o && (rem_q == 16'd1);
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = (state_q == ST_DONE);
    assign keccak_run_o       = run_q;
    assign keccak_squeezing_o = run_q;
    assign err_o              = err_q;

    // Data is forced to zero when not valid so an idle port never exposes
    // digest residue, whether or not the wipe option is built in.
    always_comb begin
        dout_data_o = '0;
        if (dout_valid_o) begin
            for (int j = 0; j < Share; j++) begin
                dout_data_o[j] = word_buf[j][idx_q];
            end
        end
    end

    // Control FSM
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rate_q  <= '0;
            rem_q   <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (zeroize_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rate_q  <= '0;
            rem_q   <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            run_q <= 1'b0;
            err_q <= start_i && ((state_q != ST_IDLE) || !start_legal);
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i && start_legal) begin
                        idx_q   <= '0;
                        rate_q  <= rate_words_i;
                        rem_q   <= len_words_i;
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (hs) begin
                        rem_q <= rem_q - 16'd1;
                        // End of request takes precedence over end of block.
                        if (rem_q == 16'd1) begin
                            idx_q   <= '0;
                            state_q <= ST_DONE;
                        end else if (idx_q + 5'd1 == rate_q) begin
                            idx_q   <= '0;
                            state_q <= ST_RUN;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (keccak_ready_i) begin
                        run_q   <= 1'b1;
                        state_q <= ST_WAIT_PERM;
                    end
                end
                ST_WAIT_PERM: begin
                    if (keccak_complete_i) begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Rate buffer
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < Share; j++) begin
                for (int k = 0; k < BufWords; k++) begin
                    word_buf[j][k] <= '0;
                end
            end
        end else if (zeroize_i) begin
            for (int j = 0; j < Share; j++) begin
                for (int k = 0; k < BufWords; k++) begin
                    word_buf[j][k] <= '0;
                end
            end
        end else begin
            if (cap_en) begin
                for (int j = 0; j < Share; j++) begin
                    for (int k = 0; k < BufWords; k++) begin
                        if (5'(k) < cap_rate) begin
                            word_buf[j][k] <= keccak_state_i[j][OutW*k +: OutW];
                        end
                    end
                end
            end
`ifdef ABR_SQUEEZE_BUF_WIPE_EN
            if (hs) begin
                for (int j = 0; j < Share; j++) begin
                    word_buf[j][idx_q] <= '0;
                end
                if (rem_q == 16'd1) begin
                    for (int j = 0; j < Share; j++) begin
                        for (int k = 0; k < BufWords; k++) begin
                            word_buf[j][k] <= '0;
                        end
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_abr_keccak_squeeze.sv
// ---------------------------------------------------------------------------
// tb_abr_keccak_squeeze
//
// Randomised bench for abr_keccak_squeeze built with two shares. A behavioural
// engine answers squeeze requests with fresh random states. The expected
// output stream is derived from the list of states handed to the DUT: word n
// comes from block n/rate, word n%rate, with the two shares side by side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_abr_keccak_squeeze;

    typedef logic [1:0][1599:0] st_t;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic             zeroize_i = 1'b0;
    logic             start_i = 1'b0;
    logic [4:0]       rate_words_i = '0;
    logic [15:0]      len_words_i = '0;
    st_t              keccak_state_i = '0;
    logic             keccak_ready_i = 1'b1;
    logic             keccak_complete_i = 1'b0;
    logic             keccak_run_o;
    logic             keccak_squeezing_o;
    logic             dout_valid_o;
    logic             dout_ready_i = 1'b0;
    logic [1:0][63:0] dout_data_o;
    logic             dout_last_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    abr_keccak_squeeze #(.EnMasking(1)) dut (
        .clk_i              (clk_i),
        .rst_n              (rst_n),
        .zeroize_i          (zeroize_i),
        .start_i            (start_i),
        .rate_words_i       (rate_words_i),
        .len_words_i        (len_words_i),
        .keccak_state_i     (keccak_state_i),
        .keccak_ready_i     (keccak_ready_i),
        .keccak_complete_i  (keccak_complete_i),
        .keccak_run_o       (keccak_run_o),
        .keccak_squeezing_o (keccak_squeezing_o),
        .dout_valid_o       (dout_valid_o),
        .dout_ready_i       (dout_ready_i),
        .dout_data_o        (dout_data_o),
        .dout_last_o        (dout_last_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .err_o              (err_o)
    );

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic st_t rand_state();
        st_t s;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 50; i++)
                s[j][32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_valid"}, 128'(dout_valid_o), 128'd0);
        check_eq({tag, "_data"},  128'(dout_data_o),  128'd0);
        check_eq({tag, "_last"},  128'(dout_last_o),  128'd0);
        check_eq({tag, "_busy"},  128'(busy_o),       128'd0);
        check_eq({tag, "_done"},  128'(done_o),       128'd0);
        check_eq({tag, "_err"},   128'(err_o),        128'd0);
        check_eq({tag, "_run"},   128'(keccak_run_o), 128'd0);
        check_eq({tag, "_sqz"},   128'(keccak_squeezing_o), 128'd0);
    endtask

    task automatic bad_start(input int rate, input int len);
        rate_words_i      = 5'(rate);
        len_words_i       = 16'(len);
        keccak_complete_i = 1'b0;
        start_i           = 1'b1;
        tick();
        start_i = 1'b0;
        check_eq("bad_err",   128'(err_o),        128'd1);
        check_eq("bad_busy",  128'(busy_o),       128'd0);
        check_eq("bad_valid", 128'(dout_valid_o), 128'd0);
        tick();
        check_eq("bad_err_clr", 128'(err_o),  128'd0);
        check_eq("bad_busy2",   128'(busy_o), 128'd0);
    endtask

    // One complete squeeze request. zero_at / busy_at (-1 = unused) pick the
    // delivered-word count at which zeroize_i or an extra start_i is driven.
    task automatic squeeze(input int rate, input int len, input int rdy_pct,
                           input int zero_at, input int busy_at);
        st_t          blocks[$];
        st_t          s;
        int           n = 0, runs = 0, eng = 0, cyc = 0, b, k;
        bit           done_seen = 0, busy_sent = 0, exp_err = 0;
        bit           pv = 0, pr = 0, pl = 0;
        logic [127:0] pd = '0;

        blocks.push_back(rand_state());
        keccak_state_i    = blocks[0];
        rate_words_i      = 5'(rate);
        len_words_i       = 16'(len);
        keccak_complete_i = 1'b0;
        dout_ready_i      = 1'b0;
        start_i           = 1'b1;
        tick();
        start_i = 1'b0;
        check_eq("first_valid", 128'(dout_valid_o), 128'd1);
        check_eq("start_busy",  128'(busy_o),       128'd1);

        while (!done_seen) begin
            if (cyc++ > 3000) begin
                check_eq("timeout_done", 128'(done_seen), 128'd1);
                return;
            end
            check_eq("err", 128'(err_o), 128'(exp_err));
            exp_err = 0;
            if (pv && !pr) begin
                check_eq("stall_valid", 128'(dout_valid_o), 128'd1);
                check_eq("stall_data",  128'(dout_data_o),  pd);
                check_eq("stall_last",  128'(dout_last_o),  128'(pl));
            end
            check_eq("sqz_eq_run", 128'(keccak_squeezing_o), 128'(keccak_run_o));
            if (keccak_run_o) begin
                runs++;
                check_eq("run_at_boundary", 128'(n), 128'(runs * rate));
                eng = $urandom_range(1, 4);
                blocks.push_back(rand_state());
            end
            if (done_o) begin
                check_eq("done_count", 128'(n), 128'(len));
                check_eq("done_valid", 128'(dout_valid_o), 128'd0);
                done_seen = 1;
            end
            if (dout_valid_o) begin
                b = n / rate;
                k = n % rate;
                if (b < blocks.size()) begin
                    s = blocks[b];
                    check_eq("data", 128'(dout_data_o), {s[1][64*k +: 64], s[0][64*k +: 64]});
                end else begin
                    check_eq("block_exists", 128'(b), 128'(blocks.size()));
                end
                check_eq("last", 128'(dout_last_o), 128'(n == len - 1));
            end
            pv = dout_valid_o;
            pd = dout_data_o;
            pl = dout_last_o;
            if (done_seen) break;

            if (zero_at >= 0 && n == zero_at) begin
                zeroize_i         = 1'b1;
                keccak_complete_i = 1'b0;
                dout_ready_i      = 1'b0;
                tick();
                zeroize_i = 1'b0;
                check_quiet("zeroize");
                tick();
                check_quiet("zeroize_hold");
                return;
            end
            if (busy_at >= 0 && n == busy_at && !busy_sent) begin
                start_i      = 1'b1;
                rate_words_i = 5'($urandom_range(1, 24));
                len_words_i  = 16'($urandom_range(1, 100));
                exp_err      = 1;
                busy_sent    = 1;
            end
            dout_ready_i = ($urandom_range(0, 99) < rdy_pct);
            pr = dout_ready_i;
            if (dout_valid_o && dout_ready_i) n++;
            if (eng > 0) begin
                eng--;
                if (eng == 0) begin
                    keccak_complete_i = 1'b1;
                    keccak_state_i    = blocks[blocks.size()-1];
                end else begin
                    keccak_complete_i = 1'b0;
                    keccak_state_i    = rand_state();
                end
            end else begin
                // Stray completes with junk state must be ignored.
                keccak_complete_i = ($urandom_range(0, 9) == 0);
                keccak_state_i    = rand_state();
            end
            keccak_ready_i = ($urandom_range(0, 3) != 0);
            tick();
            start_i = 1'b0;
        end

        keccak_complete_i = 1'b0;
        dout_ready_i      = 1'b0;
        tick();
        check_eq("done_pulse", 128'(done_o),       128'd0);
        check_eq("end_busy",   128'(busy_o),       128'd0);
        check_eq("end_valid",  128'(dout_valid_o), 128'd0);
        check_eq("run_count",  128'(runs),         128'((len + rate - 1) / rate - 1));
`ifdef ABR_SQUEEZE_BUF_WIPE_EN
        for (int j = 0; j < 2; j++)
            for (int w = 0; w < 24; w++)
                check_eq("wipe", 128'(dut.word_buf[j][w]), 128'd0);
`endif
    endtask

    initial begin
        int r, l;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_quiet("reset");
        @(negedge clk_i);
        rst_n = 1'b1;
        tick();
        check_quiet("post_reset");

        bad_start(0, 5);
        bad_start(25, 3);
        bad_start(5, 0);

        squeeze(17, 4,  100, -1, -1);
        squeeze(21, 25, 100, -1, -1);
        squeeze(17, 17, 100, -1, -1);
        squeeze(24, 30, 50,  -1, -1);
        squeeze(9,  20, 70,  -1, 3);
        squeeze(17, 30, 100, 5,  2);
        squeeze(1,  6,  50,  -1, -1);
        for (int t = 0; t < 8; t++) begin
            r = $urandom_range(1, 24);
            l = $urandom_range(1, 60);
            squeeze(r, l, 50, -1, (t % 2 == 0) ? int'($urandom_range(0, l - 1)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/abr_keccak_squeeze.md
Name: abr_keccak_squeeze

Overview:
Downstream consumer of the Keccak round engine. It snapshots the rate portion of the Keccak state after each permutation and streams it out as 64-bit words over a valid/ready interface. When the caller requests more output than one rate block holds, it issues further squeeze permutations (run plus squeezing) until the requested length is delivered. Masked shares pass through untouched and are never combined.

Parameters:
Width, 1600, Keccak state width in bits; must be a multiple of OutW.
EnMasking, 0, 1 selects two shares (Share=2), 0 selects one share (Share=1).
OutW, 64, output word width in bits.
MaxWords, Width/OutW, number of state words (25 by default); rate_words_i must be at most MaxWords-1.

Ports:
clk_i  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
zeroize_i  in  1  synchronous wipe: buffer, counters and FSM
start_i  in  1  pulse; absorb finished and keccak_state_i holds the first digest state
rate_words_i  in  5  rate in OutW words, sampled at start_i
len_words_i  in  16  total output words requested, sampled at start_i
keccak_state_i  in  Share x Width  Keccak state shares
keccak_ready_i  in  1  Keccak engine idle
keccak_complete_i  in  1  Keccak permutation-complete pulse; state is valid in the same cycle
keccak_run_o  out  1  one-cycle permutation request
keccak_squeezing_o  out  1  high together with keccak_run_o (no message XOR)
dout_valid_o  out  1  output word valid
dout_ready_i  in  1  consumer ready
dout_data_o  out  Share x OutW  output word, one slice per share
dout_last_o  out  1  qualifies the final word
busy_o  out  1  FSM not in IDLE
done_o  out  1  one-cycle pulse after the last handshake
err_o  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset and zeroize: FSM goes to IDLE. Buffer, word index and remaining count clear to 0. Every output is 0.
- Buffer: Share x (MaxWords-1) x OutW. Only the rate words are captured.
- Word order: word k of share j is keccak_state_i[j][OutW*k +: OutW], LSB first.
- Handshake: a word transfers when dout_valid_o and dout_ready_i are both high.
- While dout_valid_o is high and dout_ready_i is low, dout_data_o and dout_last_o hold stable.
- dout_last_o = dout_valid_o and (remaining == 1).
- FSM states: IDLE, STREAM, RUN, WAIT_PERM, DONE.
- IDLE:
  - start_i with rate_words_i in 1..MaxWords-1 and len_words_i != 0: capture the rate words, set idx=0 and remaining=len_words_i, go to STREAM. dout_valid_o rises the cycle after start_i.
  - start_i with illegal rate or length: pulse err_o, stay in IDLE.
- STREAM: dout_valid_o=1. On a handshake: idx++ and remaining--.
  - remaining reaches 0: go to DONE.
  - Otherwise idx reaches rate: clear idx, go to RUN.
  - Both in the same handshake: DONE wins.
- RUN: assert keccak_run_o and keccak_squeezing_o for exactly one cycle once keccak_ready_i=1, then go to WAIT_PERM. Hold in RUN while keccak_ready_i=0.
- WAIT_PERM: dout_valid_o=0. On keccak_complete_i, capture keccak_state_i and go to STREAM on the next cycle. Squeeze-block latency is 1 cycle (RUN) + the permutation + 1 cycle.
- DONE: pulse done_o for one cycle, go to IDLE.
- start_i while busy_o=1: ignored, err_o pulses, and the in-flight operation continues unaffected.
- keccak_complete_i outside WAIT_PERM: ignored.
- zeroize_i has priority over every other event in every state, including mid-stream.
- remaining is a 16-bit down-counter and never underflows. len_words_i=65535 is legal.

Optional Feature:
Macro: ABR_SQUEEZE_BUF_WIPE_EN.
- Defined: each buffer word (all shares) is zeroed in the cycle after it is handshaken. The whole buffer is zeroed on entry to DONE, so no digest residue remains.
- Not defined: buffer contents persist until the next capture, zeroize_i or reset.
- Protocol timing and outputs are identical either way.

Test Plan:
- SHA3-256, rate=17, len=4, known state pattern, dout_ready_i tied high -> words 0..3 on consecutive cycles, dout_last_o on word 3, done_o one cycle later, no keccak_run_o.
- SHAKE128, rate=21, len=25 -> 21 words, then one keccak_run_o+keccak_squeezing_o pulse. After keccak_complete_i, 4 words from the new state. dout_last_o on the 25th word.
- len equal to rate (rate=17, len=17) -> DONE reached with no RUN issued and exactly one done_o.
- Random dout_ready_i backpressure (about 50%) -> data and last stable while stalled, no dropped or duplicated words, word count equals len.
- EnMasking=1 with distinct share patterns -> dout_data_o share slices match each share independently. rate=0 or len=0 -> err_o pulse and busy_o stays 0.
- zeroize_i mid-stream at word 5, and start_i while busy -> FSM returns to IDLE with all outputs 0; the busy start gives an err_o pulse with the stream uninterrupted. With ABR_SQUEEZE_BUF_WIPE_EN, the buffer reads all-zero after DONE.
